// File: rtl/sincos_seq.sv
// -----------------------------------------------------------------------------
// sincos_seq
//   Produces the signed sin and cos of an angle given in 0.1-degree units
//   (0..3599; 3600..4095 wrap by one subtraction). One quarter-wave sine ROM is
//   shared: the angle is folded into a 0..900 ROM index plus a sign per output.
//   The ROM is read twice, sin first and then cos. Both results are then
//   published together with a one-cycle done pulse.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous reset, active-high
//   i_start      request, accepted only while o_ready=1
//   i_angle_in   angle in 0.1 deg units, sampled on the accepted cycle
//   o_ready      1 in IDLE only
//   o_rom_en     ROM read strobe, one cycle per read
//   o_rom_addr   folded ROM index 0..900, holds between reads
//   i_rom_data   ROM magnitude, valid ROM_LAT cycles after o_rom_en
//   o_sin_out    signed sin result (DW+1 bits)
//   o_cos_out    signed cos result (DW+1 bits)
//   o_done       one-cycle pulse, results valid from this cycle on
//
// state | meaning
// IDLE  | waiting for i_start, o_ready=1
// S_RD  | sin read strobe on the ROM
// S_WT  | wait ROM_LAT cycles, capture sin magnitude on the last one
// C_RD  | cos read strobe on the ROM
// C_WT  | wait ROM_LAT cycles, capture cos magnitude on the last one
// DONE  | publish sin/cos together, pulse o_done, return to IDLE
// -----------------------------------------------------------------------------
module sincos_seq #(
    parameter int DW      = 12,
    parameter int ROM_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [11:0]          i_angle_in,
    output logic                 o_ready,
    output logic                 o_rom_en,
    output logic [9:0]           o_rom_addr,
    input  logic [DW-1:0]        i_rom_data,
    output logic signed [DW:0]   o_sin_out,
    output logic signed [DW:0]   o_cos_out,
    output logic                 o_done
);

    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        S_RD,
        S_WT,
        C_RD,
        C_WT,
        DONE
    } state_t;

    state_t               r_state;
    logic [11:0]          r_a;
    logic [CW-1:0]        r_cnt;
    logic                 r_ready;
    logic                 r_rom_en;
    logic [9:0]           r_rom_addr;
    logic signed [DW:0]   r_sin_val;
    logic signed [DW:0]   r_cos_val;
    logic signed [DW:0]   r_sin_out;
    logic signed [DW:0]   r_cos_out;
    logic                 r_done;

    logic [11:0]          w_a;
    logic [9:0]           w_cos_idx;
    logic                 w_sin_neg;
    logic                 w_cos_neg;

    function automatic logic [9:0] sin_fold(input logic [11:0] a);
        if (a <= 12'd900)       return 10'(a);
        else if (a <= 12'd1800) return 10'(12'd1800 - a);
        else if (a <= 12'd2700) return 10'(a - 12'd1800);
        else                    return 10'(12'd3600 - a);
    endfunction

    function automatic logic [9:0] cos_fold(input logic [11:0] a);
        if (a <= 12'd900)       return 10'(12'd900 - a);
        else if (a <= 12'd1800) return 10'(a - 12'd900);
        else if (a <= 12'd2700) return 10'(12'd2700 - a);
        else                    return 10'(a - 12'd2700);
    endfunction

    // Negating a zero magnitude yields zero, so no special case for -0 is needed.
    function automatic logic signed [DW:0] apply_sign(input logic neg,
                                                      input logic [DW-1:0] mag);
        logic [DW:0] ext;
        ext = {1'b0, mag};
        return neg ? $signed(-ext) : $signed(ext);
    endfunction

    // Any 12-bit angle >= 3600 is below 7200, so one subtraction suffices.
    assign w_a       = (i_angle_in < 12'd3600) ? i_angle_in : i_angle_in - 12'd3600;
    assign w_cos_idx = cos_fold(r_a);
    assign w_sin_neg = (r_a > 12'd1800);
    assign w_cos_neg = (r_a >= 12'd900) && (r_a <= 12'd2700);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_sin_val  <= '0;
            r_cos_val  <= '0;
            r_sin_out  <= '0;
            r_cos_out  <= '0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        // Sin address is folded straight from the wrapped input so
                        // the strobe and address are both valid in S_RD.
                        r_a        <= w_a;
                        r_rom_en   <= 1'b1;
                        r_rom_addr <= sin_fold(w_a);
                        r_ready    <= 1'b0;
                        r_state    <= S_RD;
                    end
                end
                S_RD: begin
                    r_rom_en <= 1'b0;
                    r_cnt    <= CW'(ROM_LAT - 1);
                    r_state  <= S_WT;
                end
                S_WT: begin
                    if (r_cnt == '0) begin
                        r_sin_val  <= apply_sign(w_sin_neg, i_rom_data);
                        r_rom_en   <= 1'b1;
                        r_rom_addr <= w_cos_idx;
                        r_state    <= C_RD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                C_RD: begin
                    r_rom_en <= 1'b0;
                    r_cnt    <= CW'(ROM_LAT - 1);
                    r_state  <= C_WT;
                end
                C_WT: begin
                    if (r_cnt == '0) begin
                        r_cos_val <= apply_sign(w_cos_neg, i_rom_data);
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    r_sin_out <= r_sin_val;
                    r_cos_out <= r_cos_val;
                    r_done    <= 1'b1;
                    r_ready   <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_rom_en <= 1'b0;
                    r_ready  <= 1'b1;
                    r_done   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_rom_en   = r_rom_en;
    assign o_rom_addr = r_rom_addr;
    assign o_sin_out  = r_sin_out;
    assign o_cos_out  = r_cos_out;
    assign o_done     = r_done;

endmodule

// File: tb/tb_sincos_seq.sv
module tb_sincos_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [11:0]        angle;
    logic               ready;
    logic               rom_en;
    logic [9:0]         rom_addr;
    logic [11:0]        rom_data;
    logic signed [12:0] sin_out;
    logic signed [12:0] cos_out;
    logic               done;

    int total = 0;
    int bad   = 0;

    sincos_seq #(.DW(12), .ROM_LAT(1)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_angle_in (angle),
        .o_ready    (ready),
        .o_rom_en   (rom_en),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_sin_out  (sin_out),
        .o_cos_out  (cos_out),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    // ROM model: latency 1, data = index; junk when no read was issued.
    always @(posedge clk) rom_data <= rom_en ? 12'(rom_addr) : 12'($urandom);

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Period-3600 triangle wave: 0 at 0, +900 at 900, 0 at 1800, -900 at 2700.
    function automatic int tri_wave(input int a);
        int t;
        t = (a + 900) % 3600;
        return 900 - ((t > 1800) ? t - 1800 : 1800 - t);
    endfunction

    function automatic int ref_sin(input int ang);
        return tri_wave(ang % 3600);
    endfunction

    function automatic int ref_cos(input int ang);
        return tri_wave((ang % 3600) + 900);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic run_one(input int ang);
        int addrs[$];
        int done_c;
        int ndone;
        done_c = -1;
        ndone  = 0;
        @(negedge clk);
        check("ready_before", ready, 1);
        start = 1'b1;
        angle = 12'(ang);
        @(posedge clk);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b0;
                angle = 12'($urandom);
            end
            if (rom_en) addrs.push_back(int'(rom_addr));
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
        end
        check("latency", done_c, 5);
        check("done_count", ndone, 1);
        check("rd_count", addrs.size(), 2);
        if (addrs.size() == 2) begin
            check("sin_addr", addrs[0], iabs(ref_sin(ang)));
            check("cos_addr", addrs[1], iabs(ref_cos(ang)));
        end
        check("sin_out", sin_out, ref_sin(ang));
        check("cos_out", cos_out, ref_cos(ang));
        check("ready_after", ready, 1);
    endtask

    initial begin
        int dir[10] = '{300, 1350, 900, 2700, 3599, 3700, 0, 1800, 4095, 2250};
        int q[$];
        int last_done;
        int nd;
        int a;
        int dn;

        rst   = 1'b1;
        start = 1'b0;
        angle = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_sin", sin_out, 0);
        check("rst_cos", cos_out, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (dir[i]) run_one(dir[i]);
        for (int i = 0; i < 20; i++) run_one(int'($urandom_range(0, 4095)));

        // Reset in C_WT discards the request.
        run_one(300);
        @(negedge clk);
        start = 1'b1;
        angle = 12'd1000;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_rom_en", rom_en, 0);
        check("mid_rst_sin", sin_out, 0);
        check("mid_rst_cos", cos_out, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("mid_rst_no_done", dn, 0);
        check("mid_rst_sin_hold", sin_out, 0);

        // Start held high with a new angle every cycle.
        last_done = -1;
        nd = 0;
        for (int c = 0; c < 80 && nd < 8; c++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (q.size() == 0) begin
                    check("b2b_queue_nonempty", 0, 1);
                end else begin
                    a = q.pop_front();
                    check("b2b_sin", sin_out, ref_sin(a));
                    check("b2b_cos", cos_out, ref_cos(a));
                    check("b2b_q_empty", q.size(), 0);
                end
                if (last_done >= 0) check("b2b_spacing", c - last_done, 6);
                last_done = c;
            end
            start = 1'b1;
            angle = 12'($urandom);
            if (ready) q.push_back(int'(angle));
        end
        check("b2b_dones", nd, 8);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("final_ready", ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
